// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM: alignment mode and the load/shadow register set.
package pwm_pkg;
  localparam int PWM_MAX_CH = 32;
  localparam int PWM_MAX_W  = 16;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Sized for the largest legal instance; narrower instances only use the low bits.
  typedef struct packed {
    pwm_mode_e                            mode;
    logic [PWM_MAX_CH-1:0]                en;
    logic [PWM_MAX_W-1:0]                 period;
    logic [PWM_MAX_CH-1:0][PWM_MAX_W-1:0] duty;
  } pwm_set_t;

  function automatic pwm_set_t pwm_reset_set(input int unsigned width);
    pwm_set_t s;
    s        = '0;
    s.mode   = PWM_EDGE;
    s.period = PWM_MAX_W'((32'd1 << width) - 32'd1);
    return s;
  endfunction
endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: registered compare of the shared counter against this channel's duty.
module pwm_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  output logic             out
);
  logic out_d, out_q;

  always_comb out_d = en && (cnt < duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= 1'b0;
    else        out_q <= out_d;
  end

  assign out = out_q;
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared edge/center-aligned counter and a double-buffered
// configuration that only takes effect on a period boundary.
module pwm_multi import pwm_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               period,
  input  logic [CHANNELS-1:0][WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]            en,
  input  logic                           center,
  input  logic                           load,
  output logic                           pending,
  output logic                           period_end,
  output logic [CHANNELS-1:0]            out
);
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             dir_down_d, dir_down_q;
  logic             pending_d, pending_q;
  pwm_set_t         shadow_d, shadow_q;
  pwm_set_t         active_d, active_q;
  pwm_set_t         load_set;
  logic [WIDTH-1:0] p_act;
  logic             is_center;
  logic             boundary;
  logic             unused_active;

  always_comb begin
    load_set        = '0;
    load_set.mode   = center ? PWM_CENTER : PWM_EDGE;
    load_set.en     = PWM_MAX_CH'(en);
    load_set.period = PWM_MAX_W'(period);
    for (int i = 0; i < CHANNELS; i++) begin
      load_set.duty[i] = PWM_MAX_W'(duty[i]);
    end
  end

  assign p_act     = active_q.period[WIDTH-1:0];
  assign is_center = (active_q.mode == PWM_CENTER);

  // Boundary = last cycle of a period; with P_act=1 in center mode the turn-around is also the end.
  always_comb begin
    boundary = 1'b0;
    if (p_act == '0)
      boundary = 1'b1;
    else if (is_center)
      boundary = (cnt_q == WIDTH'(1)) && (dir_down_q || (p_act == WIDTH'(1)));
    else
      boundary = (cnt_q == p_act);
  end

  always_comb begin
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    active_d   = active_q;

    if (boundary) begin
      cnt_d      = '0;
      dir_down_d = 1'b0;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (!is_center) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (dir_down_q) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else if (cnt_q == p_act) begin
      dir_down_d = 1'b1;
      cnt_d      = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    // A load in the boundary cycle refills the shadow after the old one was consumed.
    if (load) begin
      shadow_d  = load_set;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      active_q   <= pwm_reset_set(WIDTH);
    end else begin
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_chan #(.WIDTH(WIDTH)) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (active_q.en[i]),
      .cnt  (cnt_q),
      .duty (active_q.duty[i][WIDTH-1:0]),
      .out  (out[i])
    );
  end

  // cnt is 0 only in the first cycle of a period in both modes.
  assign period_end    = rst_n && (cnt_q == '0);
  assign pending       = pending_q;
  assign unused_active = ^active_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: phase-based reference model, table vectors, corner sequences.
module tb_pwm_multi;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int NV = 6;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [W-1:0]           period = '0;
  logic [CH-1:0][W-1:0]   duty = '0;
  logic [CH-1:0]          en = '0;
  logic                   center = 1'b0;
  logic                   load = 1'b0;
  logic                   pending, period_end;
  logic [CH-1:0]          out;

  pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .period    (period),
    .duty      (duty),
    .en        (en),
    .center    (center),
    .load      (load),
    .pending   (pending),
    .period_end(period_end),
    .out       (out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: period described by phase k in 0..len-1, counter value derived from it.
  int m_p, m_c, m_pend, m_k, sh_p, sh_c;
  int m_d[CH], sh_d[CH], m_en[CH], sh_en[CH], m_out[CH];

  int          meas_len;
  int          meas_hi[CH];
  logic [31:0] meas_pat;

  typedef struct {
    int          p;
    int          d[CH];
    logic [CH-1:0] en;
    int          c;
    int          len;
    int          hi[CH];
    logic [31:0] pat0;
  } vec_t;
  vec_t vecs[NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = (1 << W) - 1; m_c = 0; m_pend = 0; m_k = 0; sh_p = 0; sh_c = 0;
    for (int i = 0; i < CH; i++) begin
      m_d[i] = 0; sh_d[i] = 0; m_en[i] = 0; sh_en[i] = 0; m_out[i] = 0;
    end
  endtask

  task automatic tick();
    int len, cnt, exp_out;
    int nout[CH];
    len = m_c ? ((m_p == 0) ? 1 : 2 * m_p) : m_p + 1;
    cnt = (m_c && m_k > m_p) ? 2 * m_p - m_k : m_k;
    for (int i = 0; i < CH; i++) nout[i] = (m_en[i] != 0 && cnt < m_d[i]) ? 1 : 0;
    if (m_k == len - 1) begin
      m_k = 0;
      if (m_pend) begin
        m_p = sh_p; m_c = sh_c; m_pend = 0;
        for (int i = 0; i < CH; i++) begin m_d[i] = sh_d[i]; m_en[i] = sh_en[i]; end
      end
    end else begin
      m_k++;
    end
    if (load) begin
      sh_p = int'(period); sh_c = int'(center); m_pend = 1;
      for (int i = 0; i < CH; i++) begin sh_d[i] = int'(duty[i]); sh_en[i] = int'(en[i]); end
    end
    exp_out = 0;
    for (int i = 0; i < CH; i++) begin
      m_out[i] = nout[i];
      exp_out |= nout[i] << i;
    end
    @(posedge clk); #1;
    check("pending", int'(pending), m_pend);
    check("period_end", int'(period_end), (m_k == 0) ? 1 : 0);
    check("out", int'(out), exp_out);
  endtask

  task automatic drive_vec(input vec_t v);
    period = W'(v.p);
    center = v.c[0];
    en     = v.en;
    for (int i = 0; i < CH; i++) duty[i] = W'(v.d[i]);
  endtask

  task automatic load_tick();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_pending_clear(input string name);
    int t = 0;
    while (pending && t < 700) begin tick(); t++; end
    check(name, int'(pending), 0);
  endtask

  // Window runs from the cycle after one period start through the next start (outputs lag by one).
  task automatic measure();
    int t = 0;
    meas_pat = '0;
    for (int i = 0; i < CH; i++) meas_hi[i] = 0;
    do begin
      tick();
      if (t < 32) meas_pat[t] = out[0];
      for (int i = 0; i < CH; i++) meas_hi[i] += int'(out[i]);
      t++;
    end while (!period_end && t < 600);
    meas_len = t;
  endtask

  initial begin
    int ones, t, p;

    vecs[0] = '{9, '{0, 3, 10, 255}, 4'b1111, 0, 10, '{0, 3, 10, 10}, 32'h0};
    vecs[1] = '{4, '{2, 0, 4, 5},    4'b1111, 1, 8,  '{3, 0, 7, 8},   32'h83};
    vecs[2] = '{0, '{0, 1, 200, 0},  4'b1011, 0, 1,  '{0, 1, 0, 0},   32'h0};
    vecs[3] = '{1, '{1, 2, 0, 1},    4'b1110, 1, 2,  '{0, 2, 0, 1},   32'h0};
    vecs[4] = '{5, '{6, 5, 1, 3},    4'b1111, 0, 6,  '{6, 5, 1, 3},   32'h3F};
    vecs[5] = '{255, '{128, 255, 0, 1}, 4'b1111, 0, 256, '{128, 255, 0, 1}, 32'h0};

    model_reset();
    #12;
    check("rst_out", int'(out), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_period_end", int'(period_end), 0);
    #6 rst_n = 1'b1;
    #1;
    check("release_period_end", int'(period_end), 1);
    repeat (5) tick();

    for (int v = 0; v < NV; v++) begin
      drive_vec(vecs[v]);
      load_tick();
      wait_pending_clear($sformatf("v%0d_pending_clear", v));
      measure();
      check($sformatf("v%0d_len", v), meas_len, vecs[v].len);
      for (int i = 0; i < CH; i++)
        check($sformatf("v%0d_hi%0d", v, i), meas_hi[i], vecs[v].hi[i]);
      if (vecs[v].len <= 32)
        check($sformatf("v%0d_pat0", v), int'(meas_pat), int'(vecs[v].pat0));
    end

    // New duty loaded mid-period must not disturb the running period.
    period = W'(9); center = 1'b0; en = 4'b1111;
    for (int i = 0; i < CH; i++) duty[i] = W'(3);
    load_tick();
    wait_pending_clear("a_setup_clear");
    repeat (3) tick();
    duty[0] = W'(7);
    load_tick();
    check("a_pending_set", int'(pending), 1);
    ones = 0; t = 0;
    while (pending && t < 700) begin tick(); ones += int'(out[0]); t++; end
    check("a_pending_clear", int'(pending), 0);
    check("a_old_duty_ones", ones, 0);
    measure();
    check("a_new_len", meas_len, 10);
    check("a_new_hi0", meas_hi[0], 7);

    // Load in the boundary cycle: earlier shadow now, newer one a period later.
    duty[0] = W'(5);
    load_tick();
    t = 0;
    while (m_k != 9 && t < 50) begin tick(); t++; end
    check("b_reach_boundary", m_k, 9);
    duty[0] = W'(8);
    load_tick();
    check("b_pending_stays", int'(pending), 1);
    check("b_period_end", int'(period_end), 1);
    measure();
    check("b_first_hi0", meas_hi[0], 5);
    check("b_pending_cleared", int'(pending), 0);
    measure();
    check("b_second_hi0", meas_hi[0], 8);

    // Reset mid-period with a pending shadow.
    for (int i = 0; i < CH; i++) duty[i] = W'(9);
    load_tick();
    repeat (2) tick();
    check("c_pending_before", int'(pending), 1);
    check("c_out_before", int'(out), 15);
    #2 rst_n = 1'b0;
    #1;
    check("c_rst_out", int'(out), 0);
    check("c_rst_pending", int'(pending), 0);
    check("c_rst_period_end", int'(period_end), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    #1;
    check("c_release_period_end", int'(period_end), 1);
    check("c_release_pending", int'(pending), 0);
    repeat (20) tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      period = W'(p);
      center = 1'($urandom_range(0, 1));
      en     = CH'($urandom);
      for (int i = 0; i < CH; i++)
        duty[i] = W'($urandom_range(0, (p + 2 > 255) ? 255 : p + 2));
      load = ($urandom_range(0, 9) == 0);
      tick();
    end
    load = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PWM outputs sharing one counter; legal range 1..32.
REQ-002 Parameter WIDTH, default 8: bit width of the counter, period and duty values; legal range 2..16.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port period  input  WIDTH  requested terminal count P; captured only on load.
REQ-006 Port duty  input  CHANNELS x WIDTH (packed array)  requested per-channel duty D[i]; captured only on load.
REQ-007 Port en  input  CHANNELS  requested per-channel enable; captured only on load.
REQ-008 Port center  input  1  requested mode (0 edge-aligned, 1 center-aligned); captured only on load.
REQ-009 Port load  input  1  single-cycle request to capture period/duty/en/center into the shadow set.
REQ-010 Port pending  output  1  high while a shadow set is waiting to be applied.
REQ-011 Port period_end  output  1  one-cycle strobe marking the first cycle of every period.
REQ-012 Port out  output  CHANNELS  PWM outputs.

Function
REQ-013 Edge mode: counter cnt SHALL count 0,1,...,P_act then wrap to 0; period length P_act+1 cycles.
REQ-014 Center mode: cnt SHALL count 0 up to P_act, then down to 1, then 0 again; period length 2*P_act cycles; P_act=0 holds cnt at 0.
REQ-015 Boundary cycle SHALL be the cycle whose next cnt value starts a new period (edge: cnt==P_act; center: cnt==1 going down; P_act=0: every cycle).
REQ-016 load=1 SHALL write all four inputs into the shadow set and set pending=1 on the next edge.
REQ-017 At a boundary with pending=1, the shadow set SHALL become the active set, cnt SHALL restart at 0 counting up, and pending SHALL clear.
REQ-018 load coinciding with a boundary: the previously pending shadow SHALL be applied, the new values SHALL overwrite the shadow, and pending SHALL remain 1.
REQ-019 Repeated loads before a boundary: only the last captured set SHALL be applied.
REQ-020 out[i] SHALL be registered: out[i] in cycle t+1 equals en_act[i] AND (cnt < D_act[i]) evaluated in cycle t.
REQ-021 D_act[i]=0 SHALL give constant low; D_act[i] > P_act SHALL give constant high (edge); center mode high-time is 2*D_act[i]-1 cycles for 1 <= D_act[i] <= P_act, constant high above.
REQ-022 period_end SHALL be high exactly in the cycles where cnt==0 at the start of a period, including every cycle when P_act=0.
REQ-023 All comparisons SHALL be unsigned WIDTH-bit; no arithmetic exceeds WIDTH bits; counter never exceeds P_act.

Reset
REQ-024 While rst_n=0: cnt=0, direction up, P_act=all ones, D_act=0, en_act=0, mode edge, shadow cleared, pending=0, period_end=0, out=0.
REQ-025 Reset asserted mid-period SHALL discard any pending shadow; first cycle after release SHALL have period_end=1.

Structure
REQ-026 Package pwm_pkg SHALL hold the mode enum (PWM_EDGE, PWM_CENTER) and the shadow-set struct typedef.
REQ-027 Per-channel compare and output register SHALL be sub-module pwm_chan, instantiated CHANNELS times; counter, shadow and pending logic stay in pwm_multi.

Verification
REQ-028 WIDTH=8: load P=9, D={0,3,10,255}, en=1111, edge -> after next boundary out = {low, 3 of 10 high, high, high}, period_end every 10 cycles.
REQ-029 Center P=4, D[0]=2 -> period 8, out[0] high 3 consecutive cycles centred on cnt=0, period_end every 8 cycles.
REQ-030 load D[0]=7 mid-period with active D=3 -> pending=1, old duty continues until boundary, new duty from the following period, pending clears.
REQ-031 load asserted exactly at boundary cycle -> earlier shadow applied now, new values one period later, pending stays 1 in between.
REQ-032 P=0 edge -> period_end constantly high, out[i]=en_act[i] AND (D_act[i]>0).
REQ-033 rst_n pulsed low mid-period with pending=1 -> all outputs 0 immediately, pending lost, period_end=1 first cycle after release.
